bs_endpoint: RTL

//  Device-side end of the bus-generator driver interface (pndng/pop/D_pop, push/D_push).
//  TX: buffers local packets, stamps header {target,source,id}, presents them to the bus as a FIFO head.
//  RX: accepts bus pushes, filters by address (own ID or broadcast), buffers them for the local consumer.
//  One instance per bus drive port; instances sit between the bus generator and each device.

---
 rtl/bs_pkg.sv | 27 ++
 rtl/bs_endpoint_if.sv | 16 +
 rtl/bs_fifo_fwft.sv | 64 ++++++
 rtl/bs_endpoint.sv | 99 +++++++++
 4 files changed

// File: rtl/bs_pkg.sv
// Shared types and constants for the bus-generator endpoint.
// The header occupies the top 32 bits of every packet.
package bs_pkg;

    localparam int         PCKG_SZ_DEF   = 128;
    localparam logic [7:0] BROADCAST_DEF = 8'hFF;
    localparam int         HDR_W         = 32;

    // Field offsets inside the 32-bit header.
    localparam int TGT_MSB = 31;
    localparam int TGT_LSB = 24;
    localparam int SRC_MSB = 23;
    localparam int SRC_LSB = 16;
    localparam int ID_MSB  = 15;
    localparam int ID_LSB  = 0;

    typedef struct packed {
        logic [TGT_MSB-TGT_LSB:0] target;
        logic [SRC_MSB-SRC_LSB:0] source;
        logic [ID_MSB-ID_LSB:0]   id;
    } bs_hdr_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] value, input logic en);
        return (en && value != 16'hFFFF) ? value + 16'd1 : value;
    endfunction

endpackage

// File: rtl/bs_endpoint_if.sv
// Bus-generator driver port: the TX head is popped by the bus, and RX packets are pushed in.
// The master side is the bus generator and the slave side is the endpoint.
interface bs_endpoint_if
    import bs_pkg::*;
#(
    parameter int PCKG_SZ = PCKG_SZ_DEF
);
    logic               pndng;
    logic [PCKG_SZ-1:0] D_pop;
    logic               pop;
    logic               push;
    logic [PCKG_SZ-1:0] D_push;

    modport master (input pndng, input D_pop, output pop, output push, output D_push);
    modport slave  (output pndng, output D_pop, input pop, input push, input D_push);
endinterface

// File: rtl/bs_fifo_fwft.sv
// First-word fall-through FIFO that uses registered storage.
// The caller must qualify wr_en and rd_en; this block assumes both are legal.
module bs_fifo_fwft #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign rd_data = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/bs_endpoint.sv
// Device-side bus endpoint: a header-stamping TX FIFO toward the bus,
// and an address-filtered RX FIFO toward the local consumer.
module bs_endpoint
    import bs_pkg::*;
#(
    parameter int         PCKG_SZ   = PCKG_SZ_DEF,
    parameter int         DEPTH     = 8,
    parameter logic [7:0] ID        = 8'd0,
    parameter logic [7:0] BROADCAST = BROADCAST_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    bs_endpoint_if.slave             bus,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    input  logic [7:0]               tx_target,
    input  logic [PCKG_SZ-HDR_W-1:0] tx_payload,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic [PCKG_SZ-1:0]       rx_data,
    output logic [15:0]              rx_drop_cnt,
    output logic [15:0]              rx_miss_cnt,
    output logic [15:0]              pop_err_cnt
);
    logic          tx_full, tx_empty, tx_wr, tx_rd;
    logic          rx_full, rx_empty, rx_wr, rx_rd, rx_hit, rx_space;
    logic [7:0]    rx_target;
    bs_hdr_t       tx_hdr;
    logic [15:0]   seq_q, seq_d;
    logic [15:0]   drop_q, drop_d, miss_q, miss_d, perr_q, perr_d;

    assign tx_ready  = !tx_full;
    assign bus.pndng = !tx_empty;
    assign rx_valid  = !rx_empty;

    assign tx_wr = tx_valid && !tx_full;
    assign tx_rd = bus.pop && !tx_empty;

    always_comb begin
        tx_hdr.target = tx_target;
        tx_hdr.source = ID;
        tx_hdr.id     = seq_q;
    end

    // A read in the same cycle frees a slot, so a full RX FIFO can still accept a packet.
    assign rx_target = bus.D_push[PCKG_SZ-HDR_W+TGT_MSB:PCKG_SZ-HDR_W+TGT_LSB];
    assign rx_hit    = (rx_target == ID) || (rx_target == BROADCAST);
    assign rx_rd     = rx_ready && !rx_empty;
    assign rx_space  = !rx_full || rx_rd;
    assign rx_wr     = bus.push && rx_hit && rx_space;

    always_comb begin
        seq_d  = tx_wr ? seq_q + 16'd1 : seq_q;
        drop_d = sat_inc(drop_q, bus.push && rx_hit && !rx_space);
        miss_d = sat_inc(miss_q, bus.push && !rx_hit);
        perr_d = sat_inc(perr_q, bus.pop && tx_empty);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seq_q  <= '0;
            drop_q <= '0;
            miss_q <= '0;
            perr_q <= '0;
        end else begin
            seq_q  <= seq_d;
            drop_q <= drop_d;
            miss_q <= miss_d;
            perr_q <= perr_d;
        end
    end

    assign rx_drop_cnt = drop_q;
    assign rx_miss_cnt = miss_q;
    assign pop_err_cnt = perr_q;

    bs_fifo_fwft #(.WIDTH(PCKG_SZ), .DEPTH(DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (tx_wr),
        .wr_data ({tx_hdr, tx_payload}),
        .rd_en   (tx_rd),
        .rd_data (bus.D_pop),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    bs_fifo_fwft #(.WIDTH(PCKG_SZ), .DEPTH(DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (rx_wr),
        .wr_data (bus.D_push),
        .rd_en   (rx_rd),
        .rd_data (rx_data),
        .full    (rx_full),
        .empty   (rx_empty)
    );

endmodule
